// File: rtl/fishingrod_pkg.sv
// Shared definitions for the Fishingrod host I/O stage: word geometry,
// controller states and a block word-select helper.
package fishingrod_pkg;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned NWORDS = 8;
    localparam int unsigned BLK_W  = 128;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT,
        ST_COLLECT,
        ST_HOLD
    } state_t;

    // Word idx of a block, word 0 being the most significant 16 bits.
    function automatic logic [WORD_W-1:0] word_of(input logic [BLK_W-1:0] blk,
                                                  input int unsigned       idx);
        return blk[BLK_W-1-WORD_W*idx -: WORD_W];
    endfunction

endpackage

// File: rtl/fishingrod_word_shift.sv
// Block register with parallel load and word-wide shift toward the MSB end;
// new words enter at the LSB end. Clear has priority over load and shift.
module fishingrod_word_shift
    import fishingrod_pkg::*;
#(
    parameter int unsigned W  = BLK_W,
    parameter int unsigned SW = WORD_W
) (
    input  logic          ck,
    input  logic          i_clr,
    input  logic          i_load,
    input  logic [W-1:0]  i_load_val,
    input  logic          i_shift,
    input  logic [SW-1:0] i_shift_in,
    output logic [W-1:0]  o_q
);

    logic [W-1:0] r_q;

    // Clear / load / shift register.
    always_ff @(posedge ck) begin
        if (i_clr) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_load_val;
        end else if (i_shift) begin
            r_q <= {r_q[W-SW-1:0], i_shift_in};
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/fishingrod_io_stage.sv
// Host interface around the Fishingrod core: accepts a 128-bit plaintext and
// key, streams them to the core as eight 16-bit words, gathers eight result
// words and offers the 128-bit ciphertext downstream.
// Optional watchdog: define FISHINGROD_IO_TIMEOUT_EN.
module fishingrod_io_stage
    import fishingrod_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic              ck,
    input  logic              rst,
    input  logic              blk_valid,
    output logic              blk_ready,
    input  logic [BLK_W-1:0]  blk_pt,
    input  logic [BLK_W-1:0]  blk_key,
    output logic              start,
    output logic [WORD_W-1:0] inp,
    output logic [WORD_W-1:0] key,
    input  logic              core_ready,
    input  logic [WORD_W-1:0] core_out,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [BLK_W-1:0]  res_ct,
    output logic              busy,
    output logic              err
);

    if (TIMEOUT_CYC < 2) begin : g_bad_timeout
        $error("fishingrod_io_stage: TIMEOUT_CYC must be at least 2");
    end

    state_t            r_state;
    logic [2:0]        r_cnt;
    logic              r_start;
    logic [WORD_W-1:0] r_inp;
    logic [WORD_W-1:0] r_key;
    logic              r_res_valid;

    logic [BLK_W-1:0]  w_pt_q;
    logic [BLK_W-1:0]  w_key_q;
    logic [BLK_W-1:0]  w_col_q;
    logic              w_accept;
    logic              w_capture;
    logic              w_done;
    logic              w_abort;
    logic              w_col_clr;

    assign w_accept  = (r_state == ST_IDLE) && blk_valid;
    assign w_capture = ((r_state == ST_WAIT) || (r_state == ST_COLLECT)) && core_ready;
    assign w_done    = (r_state == ST_COLLECT) && core_ready && (r_cnt == 3'd7);
    assign w_col_clr = rst | w_abort;

`ifdef FISHINGROD_IO_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TMO_W-1:0] r_tmo;
    logic             r_err;

    // Completing the last word wins over a watchdog hit in the same cycle.
    assign w_abort = ((r_state == ST_WAIT) || (r_state == ST_COLLECT)) &&
                     (r_tmo == TMO_W'(TIMEOUT_CYC - 1)) && !w_done;

    // Watchdog counter over WAIT/COLLECT and sticky error flag.
    always_ff @(posedge ck) begin
        if (rst) begin
            r_tmo <= '0;
            r_err <= 1'b0;
        end else begin
            if (w_abort) begin
                r_err <= 1'b1;
            end else if (w_accept) begin
                r_err <= 1'b0;
            end
            if (((r_state == ST_WAIT) || (r_state == ST_COLLECT)) && !w_done && !w_abort) begin
                r_tmo <= r_tmo + TMO_W'(1);
            end else begin
                r_tmo <= '0;
            end
        end
    end

    assign err = r_err;
`else
    assign w_abort = 1'b0;
    assign err     = 1'b0;
`endif

    fishingrod_word_shift #(.W(BLK_W), .SW(WORD_W)) u_pt_sh (
        .ck         (ck),
        .i_clr      (rst),
        .i_load     (w_accept),
        .i_load_val (blk_pt),
        .i_shift    (r_state == ST_LOAD),
        .i_shift_in ('0),
        .o_q        (w_pt_q)
    );

    fishingrod_word_shift #(.W(BLK_W), .SW(WORD_W)) u_key_sh (
        .ck         (ck),
        .i_clr      (rst),
        .i_load     (w_accept),
        .i_load_val (blk_key),
        .i_shift    (r_state == ST_LOAD),
        .i_shift_in ('0),
        .o_q        (w_key_q)
    );

    fishingrod_word_shift #(.W(BLK_W), .SW(WORD_W)) u_col_sh (
        .ck         (ck),
        .i_clr      (w_col_clr),
        .i_load     (1'b0),
        .i_load_val ('0),
        .i_shift    (w_capture),
        .i_shift_in (core_out),
        .o_q        (w_col_q)
    );

    // Controller FSM. inp/key are registered one word ahead: the serialiser
    // holds word cnt at its top, so word cnt+1 is index 1 of its contents.
    always_ff @(posedge ck) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_start     <= 1'b0;
            r_inp       <= '0;
            r_key       <= '0;
            r_res_valid <= 1'b0;
        end else begin
            r_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (blk_valid) begin
                        r_state <= ST_LOAD;
                        r_cnt   <= '0;
                        r_start <= 1'b1;
                        r_inp   <= word_of(blk_pt, 0);
                        r_key   <= word_of(blk_key, 0);
                    end
                end
                ST_LOAD: begin
                    r_cnt <= r_cnt + 3'd1;
                    if (r_cnt == 3'd7) begin
                        r_state <= ST_WAIT;
                        r_inp   <= '0;
                        r_key   <= '0;
                    end else begin
                        r_inp <= word_of(w_pt_q, 1);
                        r_key <= word_of(w_key_q, 1);
                    end
                end
                ST_WAIT: begin
                    if (w_abort) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else if (core_ready) begin
                        r_state <= ST_COLLECT;
                        r_cnt   <= 3'd1;
                    end
                end
                ST_COLLECT: begin
                    if (w_abort) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else if (core_ready) begin
                        r_cnt <= r_cnt + 3'd1;
                        if (r_cnt == 3'd7) begin
                            r_state     <= ST_HOLD;
                            r_res_valid <= 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (res_ready) begin
                        r_state     <= ST_IDLE;
                        r_res_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign blk_ready = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign start     = r_start;
    assign inp       = r_inp;
    assign key       = r_key;
    assign res_valid = r_res_valid;
    assign res_ct    = w_col_q;

endmodule

// File: tb/tb_fishingrod_io_stage.sv
// Directed self-checking bench for fishingrod_io_stage.
module tb_fishingrod_io_stage;

    logic         ck = 1'b0;
    logic         rst;
    logic         blk_valid;
    logic         blk_ready;
    logic [127:0] blk_pt;
    logic [127:0] blk_key;
    logic         start;
    logic [15:0]  inp;
    logic [15:0]  key;
    logic         core_ready;
    logic [15:0]  core_out;
    logic         res_valid;
    logic         res_ready;
    logic [127:0] res_ct;
    logic         busy;
    logic         err;

    int n_checks = 0;
    int n_err    = 0;

    localparam logic [127:0] CT_EXP = 128'hA000_A001_A002_A003_A004_A005_A006_A007;

    fishingrod_io_stage #(.TIMEOUT_CYC(16)) dut (
        .ck         (ck),
        .rst        (rst),
        .blk_valid  (blk_valid),
        .blk_ready  (blk_ready),
        .blk_pt     (blk_pt),
        .blk_key    (blk_key),
        .start      (start),
        .inp        (inp),
        .key        (key),
        .core_ready (core_ready),
        .core_out   (core_out),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_ct     (res_ct),
        .busy       (busy),
        .err        (err)
    );

    always #5 ck = ~ck;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "bench timed out");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge ck);
    endtask

    // Offer one block, then check the eight LOAD cycles. spur injects a
    // core_ready pulse in the middle of LOAD.
    task automatic send_block(input logic [127:0] pt, input logic [127:0] k, input bit spur);
        logic [127:0] ptv;
        logic [127:0] kv;
        ptv = pt;
        kv  = k;
        blk_pt    = pt;
        blk_key   = k;
        blk_valid = 1'b1;
        step(1);
        blk_valid = 1'b0;
        for (int w = 0; w < 8; w++) begin
            chk($sformatf("load_inp%0d", w), {112'd0, inp}, {112'd0, ptv[127-16*w -: 16]});
            chk($sformatf("load_key%0d", w), {112'd0, key}, {112'd0, kv[127-16*w -: 16]});
            chk($sformatf("load_start%0d", w), {127'd0, start}, {127'd0, (w == 0)});
            chk($sformatf("load_blk_ready%0d", w), {127'd0, blk_ready}, 128'd0);
            if (spur && w == 3) begin
                core_ready = 1'b1;
                core_out   = 16'hDEAD;
            end else begin
                core_ready = 1'b0;
            end
            step(1);
        end
        core_ready = 1'b0;
        chk("wait_inp", {112'd0, inp}, 128'd0);
        chk("wait_key", {112'd0, key}, 128'd0);
        chk("wait_start", {127'd0, start}, 128'd0);
        chk("wait_busy", {127'd0, busy}, 128'd1);
    endtask

    // Feed words 0xA000+i for i < n; a 3-cycle core_ready gap precedes word gap_at.
    task automatic feed(input int n, input int gap_at);
        for (int i = 0; i < n; i++) begin
            if (i == gap_at) begin
                core_ready = 1'b0;
                step(3);
                chk("gap_res_valid", {127'd0, res_valid}, 128'd0);
            end
            core_ready = 1'b1;
            core_out   = 16'hA000 + 16'(i);
            step(1);
        end
        core_ready = 1'b0;
    endtask

    task automatic check_hold(input string tag);
        chk({tag, "_res_valid"}, {127'd0, res_valid}, 128'd1);
        chk({tag, "_res_ct"}, res_ct, CT_EXP);
        chk({tag, "_blk_ready"}, {127'd0, blk_ready}, 128'd0);
    endtask

    task automatic release_hold(input string tag);
        res_ready = 1'b1;
        step(1);
        res_ready = 1'b0;
        chk({tag, "_rel_res_valid"}, {127'd0, res_valid}, 128'd0);
        chk({tag, "_rel_blk_ready"}, {127'd0, blk_ready}, 128'd1);
        chk({tag, "_rel_res_ct"}, res_ct, CT_EXP);
    endtask

    initial begin
        rst        = 1'b1;
        blk_valid  = 1'b0;
        blk_pt     = '0;
        blk_key    = '0;
        core_ready = 1'b0;
        core_out   = '0;
        res_ready  = 1'b0;

        // Reset state
        step(2);
        chk("rst_start", {127'd0, start}, 128'd0);
        chk("rst_inp", {112'd0, inp}, 128'd0);
        chk("rst_key", {112'd0, key}, 128'd0);
        chk("rst_res_valid", {127'd0, res_valid}, 128'd0);
        chk("rst_res_ct", res_ct, 128'd0);
        chk("rst_busy", {127'd0, busy}, 128'd0);
        chk("rst_err", {127'd0, err}, 128'd0);
        rst = 1'b0;
        step(1);
        chk("post_rst_blk_ready", {127'd0, blk_ready}, 128'd1);

        // Single block, core ready 5 cycles after the last LOAD word
        send_block(128'h0001_0002_0003_0004_0005_0006_0007_0008, {128{1'b1}}, 1'b0);
        step(4);
        chk("a_wait_res_valid", {127'd0, res_valid}, 128'd0);
        feed(8, -1);
        check_hold("a");

        // Output backpressure: blk_valid offered while holding
        blk_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step(1);
            check_hold($sformatf("bp%0d", c));
        end
        blk_valid = 1'b0;
        release_hold("a");

        // Gapped result
        send_block(128'h1111_2222_3333_4444_5555_6666_7777_8888,
                   128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 1'b0);
        feed(8, 4);
        check_hold("gap");
        release_hold("gap");

        // Reset mid-COLLECT, then a fresh block
        send_block(128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555, 128'h0, 1'b0);
        feed(4, -1);
        chk("mid_busy", {127'd0, busy}, 128'd1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("mr_start", {127'd0, start}, 128'd0);
        chk("mr_inp", {112'd0, inp}, 128'd0);
        chk("mr_key", {112'd0, key}, 128'd0);
        chk("mr_res_valid", {127'd0, res_valid}, 128'd0);
        chk("mr_res_ct", res_ct, 128'd0);
        chk("mr_busy", {127'd0, busy}, 128'd0);
        chk("mr_err", {127'd0, err}, 128'd0);
        chk("mr_blk_ready", {127'd0, blk_ready}, 128'd1);
        send_block(128'h0F0F_F0F0_0F0F_F0F0_0F0F_F0F0_0F0F_F0F0, 128'h5555_AAAA_5555_AAAA_5555_AAAA_5555_AAAA, 1'b0);
        feed(8, -1);
        check_hold("mr_new");
        release_hold("mr_new");

        // Spurious core_ready pulse during LOAD
        send_block(128'h0001_0002_0003_0004_0005_0006_0007_0008, 128'h0, 1'b1);
        step(1);
        chk("spur_res_valid", {127'd0, res_valid}, 128'd0);
        feed(8, -1);
        check_hold("spur");
        release_hold("spur");

`ifdef FISHINGROD_IO_TIMEOUT_EN
        // Timeout: core never answers
        send_block(128'h0, 128'h0, 1'b0);
        for (int c = 0; c < 15; c++) begin
            chk($sformatf("to_err%0d", c), {127'd0, err}, 128'd0);
            chk($sformatf("to_res_valid%0d", c), {127'd0, res_valid}, 128'd0);
            step(1);
        end
        chk("to_err15", {127'd0, err}, 128'd0);
        step(1);
        chk("to_err", {127'd0, err}, 128'd1);
        chk("to_blk_ready", {127'd0, blk_ready}, 128'd1);
        chk("to_res_valid", {127'd0, res_valid}, 128'd0);
        step(2);
        chk("to_err_sticky", {127'd0, err}, 128'd1);
        send_block(128'h0001_0002_0003_0004_0005_0006_0007_0008, 128'h0, 1'b0);
        chk("to_err_cleared", {127'd0, err}, 128'd0);
        feed(8, -1);
        check_hold("to_next");
        release_hold("to_next");
`else
        // Without the watchdog the stage waits indefinitely
        send_block(128'h0001_0002_0003_0004_0005_0006_0007_0008, 128'h0, 1'b0);
        step(40);
        chk("nto_busy", {127'd0, busy}, 128'd1);
        chk("nto_err", {127'd0, err}, 128'd0);
        chk("nto_res_valid", {127'd0, res_valid}, 128'd0);
        feed(8, -1);
        check_hold("nto");
        release_hold("nto");
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
